cheat_loader: RTL and testbench
===============================

# cheat_loader

Sequencer that sits between the HPS cheat-file download stream and the cheat code matcher. It assembles 16-byte cheat records from `ioctl` byte writes, presents each record on the matcher's 129-bit `code` bus and generates the bit-128 load strobe with guaranteed setup and hold. It also clears the matcher at reset, at the start of every cheat download and on request, and reports load status to the OSD and HPS.

## Interface
Parameters:
- `MAX_CODES`, 32: matcher capacity; `code_count` saturates here.
- `HOLD`, 2: cycles `code[127:0]` is stable before the strobe rises, and cycles the strobe stays high (≥1).

Ports:
- `clk`  in  1  system clock; one clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ioctl_download`  in  1  high for the whole cheat-file download.
- `ioctl_wr`  in  1  one-cycle byte-valid strobe.
- `ioctl_dout`  in  8  download byte.
- `clear`  in  1  one-cycle request to wipe all codes.
- `code`  out  129  to matcher: bit 128 = load strobe, 127:96 flags, 95:64 address, 63:32 compare, 31:0 replace.
- `codes_reset`  out  1  active-high clear to the matcher.
- `busy`  out  1  state ≠ IDLE, or a record is pending.
- `code_count`  out  $clog2(MAX_CODES+1)  records issued since the last clear, saturating.
- `overflow`  out  1  sticky: a completed record was dropped.
- `short_rec`  out  1  sticky: download ended mid-record.

## Operation
- Byte placement: byte i (0..15) of a record goes to word w = i>>2 and lane l = i&3. The target bits start at (3−w)*32 + l*8, so each 32-bit file word is little-endian. The assembly index wraps 15→0.
- A byte is accepted only when `ioctl_wr` is high and `ioctl_download` is high.
- Assembly register, byte index and output register are separate, so the next record assembles while the current one issues.
- One pending slot:
  - A record that completes while the FSM is outside IDLE moves to pending.
  - A record that completes while pending is already full is dropped and sets `overflow`.
- FSM states:
  - CLEAR: `codes_reset`=1 for exactly 2 cycles. `code_count`, byte index, pending, `overflow` and `short_rec` are all zeroed. Then goes to IDLE.
  - IDLE: a completed or pending record loads the output register and goes to SETUP.
  - SETUP: `code[128]`=0 with the record driven, for `HOLD` cycles, then STROBE.
  - STROBE: `code[128]`=1 for `HOLD` cycles. `code_count` increments (saturating at `MAX_CODES`) on entry. Then RELEASE.
  - RELEASE: `code[128]`=0 for 1 cycle, then IDLE.
- CLEAR entry conditions, in priority order:
  1. Reset release.
  2. `clear` pulse.
  3. Rising edge of `ioctl_download`.
- Entry into CLEAR aborts any issue in progress: `code[128]` drops in the same cycle and the pending record is discarded.
- Falling edge of `ioctl_download` with byte index ≠ 0: discard the partial record, set `short_rec`, reset the index.
- Records past `MAX_CODES` are still issued, because the matcher replaces duplicate addresses. Only the count saturates.

## Timing
- Reset values:
  - `code`=0, `code_count`=0, `overflow`=0, `short_rec`=0, `busy`=1.
  - `codes_reset`=1: the state is CLEAR while `reset_n` is low, and CLEAR runs 2 cycles after release.
- Byte 15 sampled at edge T, FSM in IDLE:
  - `code[127:0]` valid from T+1.
  - `code[128]` high from T+1+HOLD to T+2·HOLD.
  - Back in IDLE at T+2·HOLD+2.
- A pending record starts SETUP on the cycle after RELEASE.
- `clear` and a record completing in the same cycle: `clear` wins and the record is dropped without setting `overflow`.
- Edge detection on `ioctl_download` uses one register. Rising edge seen at T puts CLEAR at T+1. A byte accepted at T is also dropped, because CLEAR zeroes the index.

## Structure
- Package `cheat_pkg`:
  - FSM state enum `cl_state_t` (CLEAR, IDLE, SETUP, STROBE, RELEASE).
  - `REC_BYTES`=16, `CODE_W`=129.
  - Field offsets `FLAGS_LSB`=96, `ADDR_LSB`=64, `COMP_LSB`=32, `DATA_LSB`=0.
- Sub-module `cheat_rec_asm`: byte index, lane placement, `rec_done` pulse, partial-discard.
- `cheat_loader` holds the FSM, the pending slot, the counters and the flags.

## Test plan
- Reset release → `codes_reset`=1 for exactly 2 cycles, `code`=0, `code_count`=0, `busy` falls on cycle 3.
- Download of bytes 00 00 00 00 34 12 00 00 00 00 00 00 EA 00 00 00 → `code[127:0]` = {32'h0, 32'h00001234, 32'h0, 32'h000000EA}, strobe high for `HOLD` cycles, `code_count`=1.
- `HOLD`=20, three records with `ioctl_wr` every cycle → records 1 and 2 issued, record 3 dropped, `overflow`=1, `code_count`=2.
- 7 bytes, then `ioctl_download` falls → no strobe, `short_rec`=1, `code_count` unchanged. The next download clears `short_rec`.
- `clear` during STROBE → `code[128]`=0 the next cycle, `codes_reset` high for 2 cycles, `code_count`=0, pending empty.
- `MAX_CODES`=32, 33 records at slow rate → 33 strobes, `code_count`=32, `overflow`=0.

Source files
------------

// File: rtl/cheat_pkg.sv
// Shared types and constants for the cheat loader.
// Provides the loader FSM state type, record/bus widths, field offsets
// inside the matcher code word, the packed record payload and the
// byte-to-bit placement helper used by the record assembler.
package cheat_pkg;

  localparam int unsigned REC_BYTES = 16;
  localparam int unsigned REC_W     = REC_BYTES * 8;
  localparam int unsigned IDX_W     = $clog2(REC_BYTES);
  localparam int unsigned CODE_W    = 129;

  localparam int unsigned FLAGS_LSB = 96;
  localparam int unsigned ADDR_LSB  = 64;
  localparam int unsigned COMP_LSB  = 32;
  localparam int unsigned DATA_LSB  = 0;

  typedef enum logic [2:0] {
    CLEAR   = 3'd0,
    IDLE    = 3'd1,
    SETUP   = 3'd2,
    STROBE  = 3'd3,
    RELEASE = 3'd4
  } cl_state_t;

  // One assembled cheat record, highest field first to match the code bus.
  typedef struct packed {
    logic [31:0] flags;
    logic [31:0] addr;
    logic [31:0] comp;
    logic [31:0] data;
  } cheat_rec_t;

  // Bit offset of record byte idx: word (3-w) from the bottom, lane l inside.
  function automatic logic [6:0] byte_lsb(input logic [IDX_W-1:0] idx);
    return {~idx[3:2], idx[1:0], 3'b000};
  endfunction

endpackage

// File: rtl/cheat_rec_asm.sv
// Cheat record assembler.
// Collects download bytes into a 16-byte record, placing each byte at its
// little-endian lane inside its 32-bit word, and flags completion.
// Ports:
//   clk, reset_n      clock, async active-low reset
//   i_download        download window (bytes only accepted while high)
//   i_wr, i_byte      byte strobe and data
//   i_flush           drop the partial record and any byte this cycle
//   i_fall            download just ended; discard a partial record
//   o_rec_c           record including the byte being written this cycle
//   o_rec_done_c      the 16th byte is being accepted this cycle
//   o_short_c         a partial record is being discarded this cycle
module cheat_rec_asm
  import cheat_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_download,
  input  logic       i_wr,
  input  logic [7:0] i_byte,
  input  logic       i_flush,
  input  logic       i_fall,
  output cheat_rec_t o_rec_c,
  output logic       o_rec_done_c,
  output logic       o_short_c
);

  logic [IDX_W-1:0] r_idx;
  logic [REC_W-1:0] r_rec;
  logic [REC_W-1:0] w_rec;
  logic [6:0]       w_lsb;
  logic             w_accept;

  assign w_accept = i_wr & i_download;
  assign w_lsb    = byte_lsb(r_idx);

  // Merge the incoming byte so a completed record is usable in the same cycle.
  always_comb begin
    w_rec = r_rec;
    if (w_accept) begin
      w_rec[w_lsb +: 8] = i_byte;
    end
  end

  assign o_rec_c      = cheat_rec_t'(w_rec);
  assign o_rec_done_c = w_accept & ~i_flush & (r_idx == IDX_W'(REC_BYTES - 1));
  assign o_short_c    = ~i_flush & i_fall & (r_idx != '0);

  // Byte index wraps 15 -> 0 on its own; flush and short discard reset it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx <= '0;
      r_rec <= '0;
    end else if (i_flush) begin
      r_idx <= '0;
    end else if (o_short_c) begin
      r_idx <= '0;
    end else if (w_accept) begin
      r_rec <= w_rec;
      r_idx <= r_idx + 1'b1;
    end
  end

endmodule

// File: rtl/cheat_loader.sv
// Cheat loader: sequences assembled cheat records onto the matcher code bus.
// Each record is driven for HOLD cycles, then the load strobe (bit 128) is
// held for HOLD cycles, then released for one cycle. One record can wait
// in a pending slot while another issues. The matcher is cleared at reset,
// on a clear request and at the start of each download.
// Ports:
//   clk, reset_n                     clock, async active-low reset
//   ioctl_download/wr/dout           HPS download byte stream
//   clear                            one-cycle wipe request
//   code                             matcher bus {strobe, flags, addr, comp, data}
//   codes_reset                      matcher clear
//   busy                             loader not idle (or record pending)
//   code_count                       records issued since last clear (saturating)
//   overflow, short_rec              sticky error flags
module cheat_loader
  import cheat_pkg::*;
#(
  parameter int unsigned MAX_CODES = 32,
  parameter int unsigned HOLD      = 2
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           ioctl_download,
  input  logic                           ioctl_wr,
  input  logic [7:0]                     ioctl_dout,
  input  logic                           clear,
  output logic [CODE_W-1:0]              code,
  output logic                           codes_reset,
  output logic                           busy,
  output logic [$clog2(MAX_CODES+1)-1:0] code_count,
  output logic                           overflow,
  output logic                           short_rec
);

  localparam int unsigned CNT_W      = $clog2(MAX_CODES + 1);
  localparam int unsigned HW         = $clog2(HOLD + 1);
  localparam int unsigned CLR_CYCLES = 2;

  cl_state_t        r_state;
  logic [HW-1:0]    r_cnt;
  logic [CODE_W-1:0] r_code;
  logic             r_codes_reset;
  logic             r_busy;
  logic [CNT_W-1:0] r_count;
  logic             r_pend_vld;
  cheat_rec_t       r_pend;
  logic             r_overflow;
  logic             r_short;
  logic             r_dl_q;

  logic       w_rise;
  logic       w_fall;
  logic       w_enter_clr;
  logic       w_flush;
  logic       w_done;
  logic       w_short;
  cheat_rec_t w_rec;

  assign w_rise      = ioctl_download & ~r_dl_q;
  assign w_fall      = ~ioctl_download & r_dl_q;
  assign w_enter_clr = clear | w_rise;
  assign w_flush     = w_enter_clr | (r_state == CLEAR);

  // Download edge detector.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dl_q <= 1'b0;
    end else begin
      r_dl_q <= ioctl_download;
    end
  end

  cheat_rec_asm u_asm (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_download   (ioctl_download),
    .i_wr         (ioctl_wr),
    .i_byte       (ioctl_dout),
    .i_flush      (w_flush),
    .i_fall       (w_fall),
    .o_rec_c      (w_rec),
    .o_rec_done_c (w_done),
    .o_short_c    (w_short)
  );

  // Issue FSM with pending slot, counters and sticky flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= CLEAR;
      r_cnt         <= '0;
      r_code        <= '0;
      r_codes_reset <= 1'b1;
      r_busy        <= 1'b1;
      r_count       <= '0;
      r_pend_vld    <= 1'b0;
      r_pend        <= '0;
      r_overflow    <= 1'b0;
      r_short       <= 1'b0;
    end else if (w_enter_clr) begin
      // Abort: strobe drops now, pending and completing records are lost.
      r_state              <= CLEAR;
      r_cnt                <= '0;
      r_code[CODE_W-1]     <= 1'b0;
      r_codes_reset        <= 1'b1;
      r_busy               <= 1'b1;
      r_count              <= '0;
      r_pend_vld           <= 1'b0;
      r_overflow           <= 1'b0;
      r_short              <= 1'b0;
    end else begin
      if (w_short) begin
        r_short <= 1'b1;
      end
      if (w_done && (r_state == SETUP || r_state == STROBE)) begin
        if (r_pend_vld) begin
          r_overflow <= 1'b1;
        end else begin
          r_pend     <= w_rec;
          r_pend_vld <= 1'b1;
        end
      end
      case (r_state)
        CLEAR: begin
          if (r_cnt == HW'(CLR_CYCLES - 1)) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_codes_reset <= 1'b0;
            r_busy        <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        IDLE: begin
          if (w_done) begin
            r_code  <= {1'b0, w_rec};
            r_state <= SETUP;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        SETUP: begin
          if (r_cnt == HW'(HOLD - 1)) begin
            r_state          <= STROBE;
            r_cnt            <= '0;
            r_code[CODE_W-1] <= 1'b1;
            if (r_count != CNT_W'(MAX_CODES)) begin
              r_count <= r_count + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STROBE: begin
          if (r_cnt == HW'(HOLD - 1)) begin
            r_state          <= RELEASE;
            r_cnt            <= '0;
            r_code[CODE_W-1] <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RELEASE: begin
          // Pending record goes straight to SETUP; a record completing now
          // while the slot is still full is dropped.
          if (r_pend_vld) begin
            r_code     <= {1'b0, r_pend};
            r_pend_vld <= 1'b0;
            r_state    <= SETUP;
            if (w_done) begin
              r_overflow <= 1'b1;
            end
          end else if (w_done) begin
            r_code  <= {1'b0, w_rec};
            r_state <= SETUP;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= CLEAR;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign code        = r_code;
  assign codes_reset = r_codes_reset;
  assign busy        = r_busy;
  assign code_count  = r_count;
  assign overflow    = r_overflow;
  assign short_rec   = r_short;

endmodule

// File: tb/tb_cheat_loader.sv
// Bench for cheat_loader: directed scenarios plus randomized traffic, every
// cycle compared against a timestamp-based reference model.
module tb_cheat_loader;
  import cheat_pkg::*;

  localparam int H    = 20;
  localparam int MAXC = 32;

  logic         clk;
  logic         reset_n;
  logic         ioctl_download;
  logic         ioctl_wr;
  logic [7:0]   ioctl_dout;
  logic         clear;
  logic [128:0] code;
  logic         codes_reset;
  logic         busy;
  logic [5:0]   code_count;
  logic         overflow;
  logic         short_rec;

  cheat_loader #(.MAX_CODES(MAXC), .HOLD(H)) u_dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_dout     (ioctl_dout),
    .clear          (clear),
    .code           (code),
    .codes_reset    (codes_reset),
    .busy           (busy),
    .code_count     (code_count),
    .overflow       (overflow),
    .short_rec      (short_rec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;
  logic prev_stb = 1'b0;

  // Reference model state: time-stamped issue engine.
  longint       e;
  int           m_clr;
  int           m_idx;
  logic [7:0]   m_bytes [16];
  logic         m_dl_prev;
  logic         m_act;
  longint       m_s;
  logic [127:0] m_cur;
  logic         m_pvld;
  logic [127:0] m_pend;
  int           m_count;
  logic         m_ovf;
  logic         m_short;

  task automatic chk(input string tag, input logic [128:0] obs, input logic [128:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] build_rec();
    int lsb_of [4];
    logic [127:0] r;
    lsb_of = '{FLAGS_LSB, ADDR_LSB, COMP_LSB, DATA_LSB};
    r = '0;
    for (int i = 0; i < 16; i++) r[lsb_of[i / 4] + (i % 4) * 8 +: 8] = m_bytes[i];
    return r;
  endfunction

  task automatic model_reset();
    e = 0; m_clr = 2; m_idx = 0; m_dl_prev = 1'b0; m_act = 1'b0; m_s = 0;
    m_cur = '0; m_pvld = 1'b0; m_pend = '0; m_count = 0; m_ovf = 1'b0; m_short = 1'b0;
  endtask

  task automatic model_edge(input logic dl, input logic wr, input logic [7:0] b, input logic clr);
    logic entry, fall, done;
    logic [127:0] nrec;
    e++;
    entry = clr || (dl && !m_dl_prev);
    fall  = !dl && m_dl_prev;
    m_dl_prev = dl;
    done = 1'b0;
    nrec = '0;
    if (entry) begin
      m_clr = 2; m_idx = 0; m_act = 1'b0; m_pvld = 1'b0;
      m_count = 0; m_ovf = 1'b0; m_short = 1'b0;
    end else if (m_clr > 0) begin
      m_clr--; m_idx = 0;
    end else begin
      if (m_act && e == m_s + H) m_count = (m_count < MAXC) ? m_count + 1 : MAXC;
      if (fall && m_idx != 0) begin
        m_short = 1'b1; m_idx = 0;
      end else if (dl && wr) begin
        m_bytes[m_idx] = b;
        m_idx++;
        if (m_idx == 16) begin done = 1'b1; m_idx = 0; nrec = build_rec(); end
      end
      if (!m_act || e >= m_s + 2 * H + 1) begin
        if (m_pvld) begin
          m_act = 1'b1; m_s = e; m_cur = m_pend; m_pvld = 1'b0;
          if (done) m_ovf = 1'b1;
        end else if (done) begin
          m_act = 1'b1; m_s = e; m_cur = nrec;
        end
      end else if (done) begin
        if (m_pvld) m_ovf = 1'b1;
        else begin m_pvld = 1'b1; m_pend = nrec; end
      end
    end
  endtask

  task automatic check_all();
    logic exp_stb, exp_busy;
    exp_stb  = m_act && (e >= m_s + H) && (e <= m_s + 2 * H - 1);
    exp_busy = (m_clr > 0) || (m_act && e <= m_s + 2 * H) || m_pvld;
    chk("strobe", 129'(code[128]), 129'(exp_stb));
    if (m_act && e <= m_s + 2 * H) chk("record", 129'(code[127:0]), 129'(m_cur));
    chk("codes_reset", 129'(codes_reset), 129'(m_clr > 0));
    chk("busy", 129'(busy), 129'(exp_busy));
    chk("code_count", 129'(code_count), 129'(m_count));
    chk("overflow", 129'(overflow), 129'(m_ovf));
    chk("short_rec", 129'(short_rec), 129'(m_short));
    if (code[128] === 1'b1 && !prev_stb) pulses++;
    prev_stb = (code[128] === 1'b1);
  endtask

  task automatic step(input logic dl, input logic wr, input logic [7:0] b, input logic clr);
    ioctl_download = dl; ioctl_wr = wr; ioctl_dout = b; clear = clr;
    @(posedge clk);
    model_edge(dl, wr, b, clr);
    @(negedge clk);
    check_all();
  endtask

  task automatic start_download();
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("dl_rise_clear", 129'(codes_reset), 129'(1));
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  logic [7:0] rec0 [16];
  int hi, p0;
  logic dl_r, wr_r, clr_r;

  initial begin
    rec0 = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h34, 8'h12, 8'h00, 8'h00,
             8'h00, 8'h00, 8'h00, 8'h00, 8'hEA, 8'h00, 8'h00, 8'h00};
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_dout = 8'h00; clear = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_codes_reset", 129'(codes_reset), 129'(1));
    chk("rst_code", code, 129'(0));
    chk("rst_count", 129'(code_count), 129'(0));
    chk("rst_busy", 129'(busy), 129'(1));
    chk("rst_overflow", 129'(overflow), 129'(0));
    chk("rst_short", 129'(short_rec), 129'(0));
    reset_n = 1'b1;
    model_reset();
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("rel_cr_cycle2", 129'(codes_reset), 129'(1));
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("rel_cr_cycle3", 129'(codes_reset), 129'(0));
    chk("rel_busy_cycle3", 129'(busy), 129'(0));

    // Known record: little-endian words, address 0x1234, replace 0xEA.
    start_download();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, rec0[i], 1'b0);
    chk("rec0_code", code, {1'b0, 32'h0, 32'h00001234, 32'h0, 32'h000000EA});
    hi = 0;
    for (int k = 0; k < 2 * H + 1; k++) begin
      step(1'b1, 1'b0, 8'h00, 1'b0);
      if (code[128] === 1'b1) hi++;
    end
    chk("rec0_strobe_len", 129'(hi), 129'(H));
    chk("rec0_count", 129'(code_count), 129'(1));
    chk("rec0_idle", 129'(busy), 129'(0));

    // Short record at end of download.
    p0 = pulses;
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 8'($urandom), 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("short_set", 129'(short_rec), 129'(1));
    chk("short_count", 129'(code_count), 129'(1));
    repeat (10) step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("short_no_strobe", 129'(pulses - p0), 129'(0));
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("short_cleared", 129'(short_rec), 129'(0));
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);

    // Clear during STROBE with a record pending.
    for (int i = 0; i < 32; i++) step(1'b1, 1'b1, 8'($urandom), 1'b0);
    for (int k = 0; k < 40 && code[128] !== 1'b1; k++) step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("clr_strobe_seen", 129'(code[128]), 129'(1));
    p0 = pulses;
    step(1'b1, 1'b0, 8'h00, 1'b1);
    chk("clr_strobe_drop", 129'(code[128]), 129'(0));
    chk("clr_cr1", 129'(codes_reset), 129'(1));
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("clr_cr2", 129'(codes_reset), 129'(1));
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("clr_cr3", 129'(codes_reset), 129'(0));
    chk("clr_count", 129'(code_count), 129'(0));
    repeat (60) step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("clr_pend_gone", 129'(pulses - p0), 129'(0));
    chk("clr_idle", 129'(busy), 129'(0));

    // Three back-to-back records: one issues, one waits, one is dropped.
    start_download();
    p0 = pulses;
    for (int i = 0; i < 48; i++) step(1'b1, 1'b1, 8'($urandom), 1'b0);
    repeat (120) step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("ovf_pulses", 129'(pulses - p0), 129'(2));
    chk("ovf_count", 129'(code_count), 129'(2));
    chk("ovf_flag", 129'(overflow), 129'(1));

    // 33 records at slow rate: all issue, count saturates.
    start_download();
    p0 = pulses;
    for (int r = 0; r < 33; r++) begin
      for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 8'($urandom), 1'b0);
      repeat (2 * H + 2) step(1'b1, 1'b0, 8'h00, 1'b0);
    end
    chk("sat_pulses", 129'(pulses - p0), 129'(33));
    chk("sat_count", 129'(code_count), 129'(MAXC));
    chk("sat_overflow", 129'(overflow), 129'(0));

    // Random traffic with occasional clears and download restarts.
    dl_r = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      clr_r = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 399) == 0) dl_r = ~dl_r;
      wr_r = ($urandom_range(0, 3) != 0);
      step(dl_r, wr_r, 8'($urandom), clr_r);
    end
    repeat (100) step(dl_r, 1'b0, 8'h00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
